// File: rtl/unconfig_int_adder.sv
// Exact registered two's-complement adder: input registers, block carry-lookahead
// adder, output register. Fixed two-cycle latency, one result per clock.
module unconfig_int_adder #(
  parameter int unsigned BWOP = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  output logic [BWOP-1:0] c
);

  localparam int unsigned GW = 4;
  localparam int unsigned NG = BWOP / GW;

  if ((BWOP % GW) != 0 || BWOP < 8) begin : g_bad_width
    $error("unconfig_int_adder: BWOP must be a multiple of 4 and at least 8");
  end

  logic [BWOP-1:0] a_q;
  logic [BWOP-1:0] b_q;
  logic [BWOP-1:0] g;
  logic [BWOP-1:0] p;
  logic [BWOP-1:0] carry;
  logic [BWOP-1:0] sum;
  logic [NG-1:0]   grp_g;
  logic [NG-1:0]   grp_p;
  logic [NG:0]     grp_cin;
  logic            carry_out_unused;

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign g = a_q & b_q;
  assign p = a_q ^ b_q;

  // Per-group generate and propagate.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      grp_g[k] = g[GW*k+3]
               | (p[GW*k+3] & g[GW*k+2])
               | (p[GW*k+3] & p[GW*k+2] & g[GW*k+1])
               | (p[GW*k+3] & p[GW*k+2] & p[GW*k+1] & g[GW*k]);
      grp_p[k] = &p[GW*k +: GW];
    end
  end

  // Second-level lookahead: each group carry-in is a flat sum of products
  // over all lower groups, so no group waits on its neighbour's carry.
  always_comb begin
    logic term;
    term    = 1'b0;
    grp_cin = '0;
    for (int unsigned k = 1; k <= NG; k++) begin
      for (int unsigned j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        grp_cin[k] = grp_cin[k] | term;
      end
    end
  end

  assign carry_out_unused = grp_cin[NG];

  // Bit carries inside each group seeded by the group carry-in.
  always_comb begin
    carry = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      carry[GW*k] = grp_cin[k];
      for (int unsigned i = 0; i < GW - 1; i++) begin
        carry[GW*k+i+1] = g[GW*k+i] | (p[GW*k+i] & carry[GW*k+i]);
      end
    end
  end

  assign sum = p ^ carry;

  // Stage 2: result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
    end else begin
      c <= sum;
    end
  end

endmodule

// File: tb/tb_unconfig_int_adder.sv
// Bench for unconfig_int_adder: 32-bit and 16-bit instances checked against
// a plain-arithmetic model with a two-cycle expected-value queue.
module tb_unconfig_int_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a32, b32, c32;
  logic [15:0] a16, b16, c16;

  int checks = 0;
  int errors = 0;

  logic [31:0] q32[$];
  logic [15:0] q16[$];
  string       qn[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] e16;
    string       name;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  unconfig_int_adder #(.BWOP(32)) dut32 (.clk(clk), .rst(rst), .a(a32), .b(b32), .c(c32));
  unconfig_int_adder #(.BWOP(16)) dut16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .c(c16));

  function automatic logic [31:0] model32(input logic [31:0] x, input logic [31:0] y);
    longint s;
    s = longint'(x) + longint'(y);
    return 32'(s % 64'sd4294967296);
  endfunction

  function automatic logic [15:0] model16(input logic [15:0] x, input logic [15:0] y);
    int s;
    s = int'(x) + int'(y);
    return 16'(s % 65536);
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (32b): got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (16b): got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // At each falling edge: check the result due now, then apply the next operands.
  task automatic drive(input logic [31:0] na, input logic [31:0] nb, input logic [31:0] ne,
                       input logic [15:0] na16, input logic [15:0] nb16, input logic [15:0] ne16,
                       input string name);
    @(negedge clk);
    if (q32.size() >= 2) begin
      string n;
      n = qn.pop_front();
      chk32(n, c32, q32.pop_front());
      chk16(n, c16, q16.pop_front());
    end
    a32 = na;  b32 = nb;
    a16 = na16; b16 = nb16;
    q32.push_back(ne);
    q16.push_back(ne16);
    qn.push_back(name);
  endtask

  task automatic drive_rand(input string name);
    logic [31:0] x, y;
    logic [15:0] x16, y16;
    x = $urandom; y = $urandom;
    x16 = 16'($urandom); y16 = 16'($urandom);
    drive(x, y, model32(x, y), x16, y16, model16(x16, y16), name);
  endtask

  task automatic reset_queues(input logic [31:0] e32, input logic [15:0] e16, input string name);
    q32.delete(); q16.delete(); qn.delete();
    q32.push_back(32'h0); q16.push_back(16'h0); qn.push_back({name, "_zero"});
    q32.push_back(e32);   q16.push_back(e16);   qn.push_back(name);
  endtask

  initial begin
    tbl[0] = '{32'd100,       32'hFFFFFFE2, 32'd70,        16'h0064, 16'hFFE2, 16'h0046, "signed_pos"};
    tbl[1] = '{32'hFFFFFC18, 32'hFFFFFFE8, 32'hFFFFFC00,  16'h1234, 16'h0001, 16'h1235, "signed_neg"};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000,  16'h7FFF, 16'h0001, 16'h8000, "ovf_pos"};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  16'hFFFF, 16'hFFFF, 16'hFFFE, "minus_two"};
    tbl[4] = '{32'h80000000, 32'h80000000, 32'h00000000,  16'h8000, 16'h8000, 16'h0000, "ovf_neg"};
    tbl[5] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000,  16'hFFFF, 16'h0001, 16'h0000, "wrap_zero"};
    tbl[6] = '{32'h0FFFFFFF, 32'h00000001, 32'h10000000,  16'h0FFF, 16'h0001, 16'h1000, "cla_ripple"};
    tbl[7] = '{32'h55555555, 32'hAAAAAAAB, 32'h00000000,  16'h5555, 16'hAAAB, 16'h0000, "cla_alt"};
    tbl[8] = '{32'h00000000, 32'h00000000, 32'h00000000,  16'h0000, 16'h0000, 16'h0000, "zeros"};
    tbl[9] = '{32'h12345678, 32'h87654321, 32'h99999999,  16'hABCD, 16'h1111, 16'hBCDE, "plain"};

    // Reset held while clock runs: outputs stay zero.
    rst = 1'b0;
    a32 = 32'd5; b32 = 32'd7; a16 = 16'd5; b16 = 16'd7;
    repeat (3) begin
      @(negedge clk);
      chk32("reset_hold", c32, 32'h0);
      chk16("reset_hold", c16, 16'h0);
    end
    // Release with 5+7 held: first edge captures, second edge shows 12.
    rst = 1'b1;
    reset_queues(32'd12, 16'd12, "reset_release");
    drive(32'd5, 32'd7, 32'd12, 16'd5, 16'd7, 16'd12, "held_5_7");
    drive(32'd5, 32'd7, 32'd12, 16'd5, 16'd7, 16'd12, "held_5_7");

    // Directed boundary vectors, streamed back to back.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].a16, tbl[i].b16, tbl[i].e16, tbl[i].name);
    end

    // Random stream, new operands every cycle.
    for (int i = 0; i < 5000; i++) drive_rand("rand_stream");

    // Random operands held for several cycles each.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      logic [15:0] x16, y16;
      x = $urandom; y = $urandom;
      x16 = 16'($urandom); y16 = 16'($urandom);
      repeat ($urandom_range(2, 5)) drive(x, y, model32(x, y), x16, y16, model16(x16, y16), "rand_held");
    end

    // Mid-stream reset pulse inside one clock period with a full pipeline.
    drive(32'hDEADBEEF, 32'h11111111, model32(32'hDEADBEEF, 32'h11111111),
          16'hBEEF, 16'h1111, model16(16'hBEEF, 16'h1111), "pre_reset");
    drive(32'h01020304, 32'h10203040, 32'h11223344, 16'h0304, 16'h3040, 16'h3344, "pre_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk32("async_flush", c32, 32'h0);
    chk16("async_flush", c16, 16'h0);
    #1 rst = 1'b1;
    q32.delete(); q16.delete(); qn.delete();
    q32.push_back(32'h0); q16.push_back(16'h0); qn.push_back("post_reset_zero");
    q32.push_back(32'h0); q16.push_back(16'h0); qn.push_back("post_reset_zero");
    drive(32'h00000123, 32'h00000456, 32'h00000579, 16'h0123, 16'h0456, 16'h0579, "post_reset_first");
    for (int i = 0; i < 50; i++) drive_rand("post_reset_rand");

    // Drain remaining expected results.
    drive(32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, "drain");
    drive(32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
